// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: 2^INDEX_BITS lines of four 16-bit words.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (hit_cnt, miss_cnt).
module icache_dm #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        inv,
  output logic        i_hit,
  output logic [15:0] instr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [63:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int TAG_BITS = 14 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_ram [LINES];
  logic [63:0]         data_ram [LINES];
  logic [13:0]         miss_line_r;

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [1:0]            off_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic                  lookup_s;
  logic [15:0]           word_s;
  logic                  fill_s;
  logic                  start_miss_s;

  assign idx_s        = i_addr[INDEX_BITS+1:2];
  assign tag_s        = i_addr[15:INDEX_BITS+2];
  assign off_s        = i_addr[1:0];
  assign fill_idx_s   = miss_line_r[INDEX_BITS-1:0];
  assign fill_tag_s   = miss_line_r[13:INDEX_BITS];
  assign lookup_s     = valid_r[idx_s] && (tag_ram[idx_s] == tag_s);
  assign word_s       = data_ram[idx_s][{off_s, 4'b0000} +: 16];
  assign fill_s       = (state_r == REFILL) && mem_rdy;
  assign start_miss_s = (state_r == IDLE) && (state_nxt_s == REFILL);
  assign mem_addr     = {miss_line_r, 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a miss with inv low starts a refill; mem_rdy ends it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!i_hit && !inv) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REFILL: begin
        if (mem_rdy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: lookup is only live in IDLE, and instr is zero without a hit
  always_comb begin
    i_hit  = 1'b0;
    instr  = 16'h0000;
    mem_rd = 1'b0;
    case (state_r)
      IDLE: begin
        i_hit = lookup_s && !inv;
        if (i_hit) begin
          instr = word_s;
        end else begin
          instr = 16'h0000;
        end
      end
      REFILL: mem_rd = 1'b1;
      default: begin
        i_hit  = 1'b0;
        mem_rd = 1'b0;
      end
    endcase
  end

  // Valid bits: inv wins over a fill landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (inv) begin
      valid_r <= {LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Latched miss line, held stable for the whole refill
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_line_r <= 14'h0000;
    end else if (start_miss_s) begin
      miss_line_r <= i_addr[15:2];
    end
  end

  // Tag and data arrays are not reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (fill_s && !rst) begin
      tag_ram[fill_idx_s]  <= fill_tag_s;
      data_ram[fill_idx_s] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (i_hit && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'h0001;
      end
      if (start_miss_s && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule
